// File: rtl/dvl_pkg.sv
// Shared DVL front-end definitions: H-bridge burst states and gate patterns.
// Gate patterns are packed {lh, ll, rh, rl}.
package dvl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GUARD,
        PH_A,
        DEAD_AB,
        PH_B,
        DEAD_BA,
        BRAKE
    } hb_state_t;

    localparam logic [3:0] HB_OFF   = 4'b0000;
    localparam logic [3:0] HB_PH_A  = 4'b1001;
    localparam logic [3:0] HB_PH_B  = 4'b0110;
    localparam logic [3:0] HB_BRAKE = 4'b0101;

    function automatic logic [3:0] hb_pattern(input hb_state_t s);
        case (s)
            PH_A:    return HB_PH_A;
            PH_B:    return HB_PH_B;
            BRAKE:   return HB_BRAKE;
            default: return HB_OFF;
        endcase
    endfunction

    // Inverting a channel swaps its left and right half-bridges, which turns
    // PH_A into PH_B and back while leaving OFF and BRAKE unchanged.
    function automatic logic [3:0] hb_swap_sides(input logic [3:0] p);
        return {p[1:0], p[3:2]};
    endfunction

endpackage

// File: rtl/hb_timer.sv
// Loadable down-counter shared by the guard, phase, dead-time and brake intervals.
// After a load of L, expire is high in the L-th cycle; it never wraps below 1.
module hb_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt > W'(1)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt <= W'(1));

endmodule

// File: rtl/hb_burst_ctrl.sv
// Multi-channel H-bridge transmit burst controller: guard, N full-bridge cycles
// with dead time, optional terminal brake, abort, all outputs registered.
module hb_burst_ctrl
    import dvl_pkg::*;
#(
    parameter int NUM_CH       = 1,
    parameter int PERIOD_W     = 16,
    parameter int COUNT_W      = 8,
    parameter int DEADTIME     = 2,
    parameter int GUARD_CYCLES = 4,
    parameter int BRAKE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] half_period,
    input  logic [COUNT_W-1:0]  num_cycles,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic [NUM_CH-1:0]   ch_inv,
    input  logic                brake_en,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                txrx,
    output logic [NUM_CH-1:0]   hlh,
    output logic [NUM_CH-1:0]   hll,
    output logic [NUM_CH-1:0]   hrh,
    output logic [NUM_CH-1:0]   hrl
);

    hb_state_t state, state_nx;

    logic [PERIOD_W-1:0] hp_q;
    logic [COUNT_W-1:0]  cyc_q, cyc_nx;
    logic [NUM_CH-1:0]   ch_en_q, ch_inv_q;
    logic                brake_q;
    logic                abort_pend, abort_pend_nx;
    logic                aborted_q, aborted_nx;
    logic                busy_q, done_q, done_nx;
    logic                latch;

    logic                tmr_load, tmr_expire;
    logic [PERIOD_W-1:0] tmr_value;

    logic [3:0]                   pattern_nx;
    logic [NUM_CH-1:0][3:0]       gate_nx, gate_q;

    hb_timer #(.W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    // NOTE: every signal assigned below gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nx      = state;
        abort_pend_nx = abort_pend;
        aborted_nx    = aborted_q;
        cyc_nx        = cyc_q;
        tmr_load      = 1'b0;
        tmr_value     = hp_q;
        done_nx       = 1'b0;
        latch         = 1'b0;

        if (state != IDLE && abort) begin
            abort_pend_nx = 1'b1;
            aborted_nx    = 1'b1;
        end

        case (state)
            IDLE: begin
                abort_pend_nx = 1'b0;
                if (start) begin
                    latch      = 1'b1;
                    aborted_nx = 1'b0;
                    if (num_cycles == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx  = GUARD;
                        cyc_nx    = num_cycles;
                        tmr_load  = 1'b1;
                        tmr_value = PERIOD_W'(GUARD_CYCLES);
                    end
                end
            end

            GUARD, PH_A, PH_B, BRAKE: begin
                if (abort) begin
                    // Drop straight into dead time; the pending flag sends it home.
                    state_nx  = (state == PH_A) ? DEAD_AB : DEAD_BA;
                    tmr_load  = 1'b1;
                    tmr_value = PERIOD_W'(DEADTIME);
                end else if (tmr_expire) begin
                    tmr_load = 1'b1;
                    case (state)
                        GUARD: state_nx = PH_A;
                        PH_A: begin
                            state_nx  = DEAD_AB;
                            tmr_value = PERIOD_W'(DEADTIME);
                        end
                        PH_B: begin
                            state_nx  = DEAD_BA;
                            tmr_value = PERIOD_W'(DEADTIME);
                        end
                        default: begin
                            state_nx = IDLE;
                            tmr_load = 1'b0;
                            done_nx  = 1'b1;
                        end
                    endcase
                end
            end

            DEAD_AB: begin
                if (tmr_expire) begin
                    if (abort_pend_nx) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = PH_B;
                        tmr_load = 1'b1;
                    end
                end
            end

            DEAD_BA: begin
                if (tmr_expire) begin
                    if (abort_pend_nx) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else if (cyc_q == COUNT_W'(1)) begin
                        if (brake_q) begin
                            state_nx  = BRAKE;
                            tmr_load  = 1'b1;
                            tmr_value = PERIOD_W'(BRAKE_CYCLES);
                        end else begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end
                    end else begin
                        cyc_nx   = cyc_q - 1'b1;
                        state_nx = PH_A;
                        tmr_load = 1'b1;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // Gates are decoded from the next state so the registered outputs line up
    // exactly with the state register.
    assign pattern_nx = hb_pattern(state_nx);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign gate_nx[i] = !ch_en_q[i] ? HB_OFF :
                            ch_inv_q[i] ? hb_swap_sides(pattern_nx) : pattern_nx;
        assign hlh[i] = gate_q[i][3];
        assign hll[i] = gate_q[i][2];
        assign hrh[i] = gate_q[i][1];
        assign hrl[i] = gate_q[i][0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            abort_pend <= 1'b0;
            aborted_q  <= 1'b0;
            cyc_q      <= '0;
            hp_q       <= '0;
            ch_en_q    <= '0;
            ch_inv_q   <= '0;
            brake_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            gate_q     <= '0;
        end else begin
            state      <= state_nx;
            abort_pend <= abort_pend_nx;
            aborted_q  <= aborted_nx;
            cyc_q      <= cyc_nx;
            busy_q     <= (state_nx != IDLE);
            done_q     <= done_nx;
            gate_q     <= gate_nx;
            if (latch) begin
                hp_q     <= (half_period == '0) ? PERIOD_W'(1) : half_period;
                ch_en_q  <= ch_en;
                ch_inv_q <= ch_inv;
                brake_q  <= brake_en;
            end
        end
    end

    assign busy    = busy_q;
    assign txrx    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule
